// File: rtl/bias_bank_loader_l17.sv
// Bias bank loader for the layer-17 4:1 bias mux: fills four banks from a serial
// valid/ready word stream, then steps the bank select z once per adder-tree group.
module bias_bank_loader_l17 #(
    parameter int unsigned N_adder_tree = 16,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic [17:0]                bias_in,
    input  logic                       bias_valid,
    output logic                       bias_ready,
    input  logic                       run_start,
    input  logic                       group_done,
    output logic [N_adder_tree*18-1:0] BIAS_1,
    output logic [N_adder_tree*18-1:0] BIAS_2,
    output logic [N_adder_tree*18-1:0] BIAS_3,
    output logic [N_adder_tree*18-1:0] BIAS_4,
    output logic [1:0]                 z,
    output logic                       banks_loaded,
    output logic                       busy,
    output logic                       pass_done
);

    localparam int unsigned BusW = N_adder_tree * 18;

    typedef enum logic [1:0] {StIdle, StLoad, StReady, StRun} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       bank_cnt_q, bank_cnt_d;
    logic [1:0]       z_q, z_d;
    logic             loaded_q, loaded_d;
    logic             pass_done_q, pass_done_d;
    logic [BusW-1:0]  bank_q [4];
    logic             accept;
    logic             last_word;

    assign accept    = (state_q == StLoad) && bias_valid;
    assign last_word = (bank_cnt_q == 2'd3) && (word_cnt_q == CNT_W'(N_adder_tree - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        bank_cnt_d  = bank_cnt_q;
        z_d         = z_q;
        loaded_d    = loaded_q;
        pass_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d    = StLoad;
                    word_cnt_d = '0;
                    bank_cnt_d = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (last_word) begin
                        state_d    = StReady;
                        loaded_d   = 1'b1;
                        word_cnt_d = '0;
                        bank_cnt_d = '0;
                    end else if (word_cnt_q == CNT_W'(N_adder_tree - 1)) begin
                        word_cnt_d = '0;
                        bank_cnt_d = bank_cnt_q + 2'd1;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            StReady: begin
                // load_start has priority over run_start
                if (load_start) begin
                    state_d    = StLoad;
                    loaded_d   = 1'b0;
                    word_cnt_d = '0;
                    bank_cnt_d = '0;
                end else if (run_start) begin
                    state_d = StRun;
                    z_d     = 2'd0;
                end
            end
            StRun: begin
                if (group_done) begin
                    if (z_q == 2'd3) begin
                        z_d         = 2'd0;
                        pass_done_d = 1'b1;
                        state_d     = StReady;
                    end else begin
                        z_d = z_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q  <= '0;
            bank_cnt_q  <= '0;
            z_q         <= '0;
            loaded_q    <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            bank_cnt_q  <= bank_cnt_d;
            z_q         <= z_d;
            loaded_q    <= loaded_d;
            pass_done_q <= pass_done_d;
        end
    end

    // Only the addressed 18-bit slice is written; every other word holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                bank_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                for (int w = 0; w < int'(N_adder_tree); w++) begin
                    if (accept && (bank_cnt_q == 2'(b)) && (word_cnt_q == CNT_W'(w))) begin
                        bank_q[b][w*18 +: 18] <= bias_in;
                    end
                end
            end
        end
    end

    assign bias_ready   = (state_q == StLoad);
    assign busy         = (state_q == StLoad) || (state_q == StRun);
    assign BIAS_1       = bank_q[0];
    assign BIAS_2       = bank_q[1];
    assign BIAS_3       = bank_q[2];
    assign BIAS_4       = bank_q[3];
    assign z            = z_q;
    assign banks_loaded = loaded_q;
    assign pass_done    = pass_done_q;

endmodule

// File: tb/tb_bias_bank_loader_l17.sv
// Directed self-checking bench for bias_bank_loader_l17 with four words per bank.
module tb_bias_bank_loader_l17;

    localparam int unsigned N = 4;
    localparam int unsigned W = N * 18;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_start;
    logic [17:0]  bias_in;
    logic         bias_valid;
    logic         bias_ready;
    logic         run_start;
    logic         group_done;
    logic [W-1:0] bias_1, bias_2, bias_3, bias_4;
    logic [1:0]   z;
    logic         banks_loaded;
    logic         busy;
    logic         pass_done;

    int n_cmp = 0;
    int n_err = 0;

    bias_bank_loader_l17 #(
        .N_adder_tree(N),
        .CNT_W       (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .bias_in     (bias_in),
        .bias_valid  (bias_valid),
        .bias_ready  (bias_ready),
        .run_start   (run_start),
        .group_done  (group_done),
        .BIAS_1      (bias_1),
        .BIAS_2      (bias_2),
        .BIAS_3      (bias_3),
        .BIAS_4      (bias_4),
        .z           (z),
        .banks_loaded(banks_loaded),
        .busy        (busy),
        .pass_done   (pass_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_bank(input int b);
        logic [W-1:0] v;
        v = '0;
        for (int w = 0; w < int'(N); w++) v[w*18 +: 18] = 18'(b * 4 + w + 1);
        return v;
    endfunction

    // Full no-stall load of words 1..16, with word 8 (bank 2 word 0) replaced by w8.
    task automatic do_load(input logic [17:0] w8);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bias_valid = 1'b1;
            bias_in    = (i == 8) ? w8 : 18'(i + 1);
            @(negedge clk);
        end
        bias_valid = 1'b0;
        bias_in    = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] exp1;
        rst_n      = 1'b0;
        load_start = 1'b0;
        bias_in    = '0;
        bias_valid = 1'b0;
        run_start  = 1'b0;
        group_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bias_1, bias_2, bias_3, bias_4} !== '0) begin
            n_err++; $display("FAIL reset_banks: got nonzero bank data, expected 0");
        end
        n_cmp++;
        if ({z, banks_loaded, bias_ready, busy, pass_done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got z=%0d ld=%b rdy=%b busy=%b pd=%b, expected all 0",
                     z, banks_loaded, bias_ready, busy, pass_done);
        end
        // run_start in IDLE must be ignored
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL idle_run_ignored: got busy=%b, expected 0", busy);
        end
        // partial load of five words, then asynchronous reset
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bias_valid = 1'b1;
            bias_in    = 18'(i + 1);
            @(negedge clk);
        end
        bias_valid = 1'b0;
        exp1 = ref_bank(0);
        n_cmp++;
        if (bias_1 !== exp1 || bias_2[17:0] !== 18'h5 || bias_ready !== 1'b1) begin
            n_err++;
            $display("FAIL partial_load: got b1=%h b2w0=%h rdy=%b, expected b1=%h b2w0=5 rdy=1",
                     bias_1, bias_2[17:0], bias_ready, exp1);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bias_1, bias_2, bias_3, bias_4} !== '0 ||
            {z, banks_loaded, bias_ready, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL midload_reset: got b1=%h b2=%h z=%0d ld=%b rdy=%b busy=%b, expected 0",
                     bias_1, bias_2, z, banks_loaded, bias_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        int ready_cnt;
        logic [W-1:0] bus [4];
        logic [W-1:0] expv;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        ready_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bias_ready) ready_cnt++;
            if (i == 15) begin
                n_cmp++;
                if (banks_loaded !== 1'b0) begin
                    n_err++; $display("FAIL loaded_early: got %b before last word, expected 0",
                                      banks_loaded);
                end
            end
            if (i == 16) begin
                n_cmp++;
                if (banks_loaded !== 1'b1) begin
                    n_err++; $display("FAIL loaded_latency: got %b after last word, expected 1",
                                      banks_loaded);
                end
            end
            bias_valid = 1'b1;
            bias_in    = (i < 16) ? 18'(i + 1) : 18'h3ABCD;
            @(negedge clk);
        end
        bias_valid = 1'b0;
        n_cmp++;
        if (ready_cnt != 16) begin
            n_err++; $display("FAIL ready_cycles: got %0d, expected 16", ready_cnt);
        end
        bus[0] = bias_1; bus[1] = bias_2; bus[2] = bias_3; bus[3] = bias_4;
        for (int b = 0; b < 4; b++) begin
            expv = ref_bank(b);
            n_cmp++;
            if (bus[b] !== expv) begin
                n_err++; $display("FAIL full_load_bank%0d: got %h, expected %h", b, bus[b], expv);
            end
        end
    endtask

    task automatic test_stalled_load();
        int k;
        logic [W-1:0] bus [4];
        logic [W-1:0] expv;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        n_cmp++;
        if (banks_loaded !== 1'b0 || bias_ready !== 1'b1) begin
            n_err++; $display("FAIL reload_entry: got ld=%b rdy=%b, expected ld=0 rdy=1",
                              banks_loaded, bias_ready);
        end
        k = 0;
        for (int i = 0; i < 48 && k < 16; i++) begin
            if (i % 2 == 0) begin
                bias_valid = 1'b1;
                bias_in    = 18'(k + 1);
                k++;
            end else begin
                bias_valid = 1'b0;
                bias_in    = 18'h2AAAA;
            end
            @(negedge clk);
        end
        bias_valid = 1'b1;
        bias_in    = 18'h15555;
        n_cmp++;
        if (bias_ready !== 1'b0 || banks_loaded !== 1'b1) begin
            n_err++; $display("FAIL extra_word: got rdy=%b ld=%b, expected rdy=0 ld=1",
                              bias_ready, banks_loaded);
        end
        @(negedge clk);
        bias_valid = 1'b0;
        bus[0] = bias_1; bus[1] = bias_2; bus[2] = bias_3; bus[3] = bias_4;
        for (int b = 0; b < 4; b++) begin
            expv = ref_bank(b);
            n_cmp++;
            if (bus[b] !== expv) begin
                n_err++; $display("FAIL stall_load_bank%0d: got %h, expected %h", b, bus[b], expv);
            end
        end
    endtask

    task automatic test_pass();
        // group_done in READY must be ignored
        group_done = 1'b1;
        @(negedge clk);
        group_done = 1'b0;
        n_cmp++;
        if (z !== 2'd0 || pass_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL ready_group_ignored: got z=%0d pd=%b busy=%b, expected 0 0 0",
                              z, pass_done, busy);
        end
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || z !== 2'd0) begin
            n_err++; $display("FAIL run_entry: got busy=%b z=%0d, expected busy=1 z=0", busy, z);
        end
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (z !== 2'(g) || pass_done !== 1'b0) begin
                n_err++; $display("FAIL z_hold%0d: got z=%0d pd=%b, expected z=%0d pd=0",
                                  g, z, pass_done, g);
            end
            group_done = 1'b1;
            @(negedge clk);
            group_done = 1'b0;
            n_cmp++;
            if (z !== 2'((g + 1) % 4) || pass_done !== (g == 3)) begin
                n_err++; $display("FAIL z_step%0d: got z=%0d pd=%b, expected z=%0d pd=%b",
                                  g, z, pass_done, (g + 1) % 4, (g == 3));
            end
            repeat (2) @(negedge clk);
        end
        n_cmp++;
        if (pass_done !== 1'b0 || busy !== 1'b0 || z !== 2'd0 || banks_loaded !== 1'b1) begin
            n_err++; $display("FAIL pass_end: got pd=%b busy=%b z=%0d ld=%b, expected 0 0 0 1",
                              pass_done, busy, z, banks_loaded);
        end
    endtask

    task automatic test_conflicts();
        load_start = 1'b1;
        run_start  = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run_start  = 1'b0;
        n_cmp++;
        if (bias_ready !== 1'b1 || z !== 2'd0 || banks_loaded !== 1'b0) begin
            n_err++; $display("FAIL load_wins: got rdy=%b z=%0d ld=%b, expected rdy=1 z=0 ld=0",
                              bias_ready, z, banks_loaded);
        end
        for (int i = 0; i < 16; i++) begin
            bias_valid = 1'b1;
            bias_in    = 18'(i + 1);
            @(negedge clk);
        end
        bias_valid = 1'b0;
        run_start  = 1'b1;
        @(negedge clk);
        run_start  = 1'b0;
        group_done = 1'b1;
        @(negedge clk);
        group_done = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        n_cmp++;
        if (bias_ready !== 1'b0 || busy !== 1'b1 || z !== 2'd1) begin
            n_err++; $display("FAIL run_load_ignored: got rdy=%b busy=%b z=%0d, expected 0 1 1",
                              bias_ready, busy, z);
        end
        group_done = 1'b1;
        @(negedge clk);
        group_done = 1'b0;
        n_cmp++;
        if (z !== 2'd2) begin
            n_err++; $display("FAIL run_z_advance: got z=%0d, expected 2", z);
        end
        repeat (2) begin
            group_done = 1'b1;
            @(negedge clk);
            group_done = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || z !== 2'd0) begin
            n_err++; $display("FAIL conflict_pass_end: got busy=%b z=%0d, expected 0 0", busy, z);
        end
    endtask

    task automatic test_negative();
        do_load(18'h3FFFF);
        n_cmp++;
        if (bias_3[17:0] !== 18'h3FFFF || bias_3[35:18] !== 18'h0000A) begin
            n_err++; $display("FAIL neg_one: got w0=%h w1=%h, expected w0=3ffff w1=0000a",
                              bias_3[17:0], bias_3[35:18]);
        end
        do_load(18'h20000);
        n_cmp++;
        if (bias_3[17:0] !== 18'h20000 || bias_3[35:18] !== 18'h0000A) begin
            n_err++; $display("FAIL most_neg: got w0=%h w1=%h, expected w0=20000 w1=0000a",
                              bias_3[17:0], bias_3[35:18]);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stalled_load();
        test_pass();
        test_conflicts();
        test_negative();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
